// File: rtl/mux5_arbiter_if.sv
// Request/data/select bundle between the five channel sources,
// the arbiter, and the LEDR consumer.
interface mux5_arbiter_if;
    logic [4:0]  req;
    logic [14:0] data_in;
    logic        out_ready;
    logic [2:0]  sel;
    logic [4:0]  grant;
    logic [2:0]  out_data;
    logic        out_valid;
    logic        busy;

    modport master (
        output req,
        output data_in,
        output out_ready,
        input  sel,
        input  grant,
        input  out_data,
        input  out_valid,
        input  busy
    );

    modport slave (
        input  req,
        input  data_in,
        input  out_ready,
        output sel,
        output grant,
        output out_data,
        output out_valid,
        output busy
    );
endinterface

// File: rtl/mux5_arbiter.sv
// Round-robin arbiter/sequencer for the five-channel 3-bit switch mux.
// Define MUX5_ARB_PRIORITY_EN to give channel 4 absolute priority in IDLE.
module mux5_arbiter #(
    parameter int HOLD_CYCLES = 4
) (
    input  logic          CLOCK_50,
    input  logic          KEY0,
    mux5_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam logic [7:0] HOLD_M1 = 8'(HOLD_CYCLES - 1);

    state_t     state_q, state_d;
    logic [2:0] sel_q, sel_d;
    logic [4:0] grant_q, grant_d;
    logic       out_valid_q, out_valid_d;
    logic       busy_q, busy_d;
    logic [2:0] last_q, last_d;
    logic [7:0] cnt_q, cnt_d;

    logic       rr_vld;
    logic [2:0] rr_idx;
    logic [2:0] rr_c;
    logic [2:0] pick;
    logic       req_sel;
    logic [2:0] out_data_w;

    function automatic logic [2:0] nxt_ch(input logic [2:0] c);
        return (c == 3'd4) ? 3'd0 : c + 3'd1;
    endfunction

    function automatic logic [4:0] onehot(input logic [2:0] c);
        logic [4:0] r;
        r = 5'b0;
        unique case (c)
            3'd0:    r = 5'b00001;
            3'd1:    r = 5'b00010;
            3'd2:    r = 5'b00100;
            3'd3:    r = 5'b01000;
            3'd4:    r = 5'b10000;
            default: r = 5'b00000;
        endcase
        return r;
    endfunction

    // Search begins one past the last completed channel, wrapping 4->0.
    always_comb begin
        rr_vld = 1'b0;
        rr_idx = 3'd0;
        rr_c   = last_q;
        for (int k = 0; k < 5; k++) begin
            rr_c = nxt_ch(rr_c);
            if (!rr_vld && bus.req[rr_c]) begin
                rr_vld = 1'b1;
                rr_idx = rr_c;
            end
        end
    end

    always_comb begin
        pick = rr_idx;
`ifdef MUX5_ARB_PRIORITY_EN
        if (bus.req[4]) begin
            pick = 3'd4;
        end
`endif
    end

    // grant_q is one-hot on sel_q while in GRANT, so this is req[sel].
    assign req_sel = |(bus.req & grant_q);

    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        grant_d     = grant_q;
        out_valid_d = out_valid_q;
        busy_d      = busy_q;
        last_d      = last_q;
        cnt_d       = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (rr_vld) begin
                    state_d     = GRANT;
                    sel_d       = pick;
                    grant_d     = onehot(pick);
                    out_valid_d = 1'b1;
                    busy_d      = 1'b1;
                end
            end
            GRANT: begin
                if (out_valid_q && bus.out_ready) begin
                    state_d     = HOLD;
                    last_d      = sel_q;
                    cnt_d       = HOLD_M1;
                    out_valid_d = 1'b0;
                end else if (!req_sel) begin
                    state_d     = IDLE;
                    grant_d     = 5'b0;
                    out_valid_d = 1'b0;
                    busy_d      = 1'b0;
                end
            end
            HOLD: begin
                if (cnt_q == 8'd0) begin
                    state_d = IDLE;
                    grant_d = 5'b0;
                    busy_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            default: begin
                state_d     = IDLE;
                grant_d     = 5'b0;
                out_valid_d = 1'b0;
                busy_d      = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge KEY0) begin
        if (!KEY0) begin
            state_q     <= IDLE;
            sel_q       <= 3'd0;
            grant_q     <= 5'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            last_q      <= 3'd4;
            cnt_q       <= 8'd0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            grant_q     <= grant_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            last_q      <= last_d;
            cnt_q       <= cnt_d;
        end
    end

    always_comb begin
        out_data_w = 3'd0;
        unique case (sel_q)
            3'd0:    out_data_w = bus.data_in[2:0];
            3'd1:    out_data_w = bus.data_in[5:3];
            3'd2:    out_data_w = bus.data_in[8:6];
            3'd3:    out_data_w = bus.data_in[11:9];
            3'd4:    out_data_w = bus.data_in[14:12];
            default: out_data_w = 3'd0;
        endcase
    end

    assign bus.sel       = sel_q;
    assign bus.grant     = grant_q;
    assign bus.out_valid = out_valid_q;
    assign bus.busy      = busy_q;
    assign bus.out_data  = out_data_w;

endmodule
